// File: rtl/ram_responder.sv
// ram_responder
//   Byte-wide RAM-side responder for the memory controller. Requests are
//   sampled on the rising edge of clk_in. Reads return their byte one cycle
//   later on ramData_out. Addresses in the 8-byte I/O window at IO_BASE are
//   routed to peripherals instead of the storage array.
//
//   I/O window map:
//     +0 write : push byte into TX FIFO (dropped and overflow flagged if full
//                and no pop this cycle)
//     +0 read  : FIFO occupancy
//     +4 write : set sticky halt
//     +4 read  : counter byte 0, and snapshot the full counter into snap
//     +5..+7   : snap bytes 1..3
//     +1..+3   : read as 0
//
//   Optional feature macro: CYCLE_CNT_EN. When it is defined, the cycle
//   counter and snapshot are built. Otherwise +4..+7 read as 0; the +4 write
//   still sets halt.
//
//   Ports:
//     clk_in, rst_in (async, active-low)
//     en_in, ramRW_in (0 read / 1 write), ramAddr_in[31:0], ramData_in[7:0]
//     ramData_out[7:0] : registered read byte
//     txData_out, txValid_out, txReady_in : FIFO drain port
//     halt_out     : sticky halt
//     overflow_out : sticky dropped-character flag
module ram_responder #(
    parameter int unsigned RAM_AW     = 17,
    parameter logic [31:0] IO_BASE    = 32'h0003_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        en_in,
    input  logic        ramRW_in,
    input  logic [31:0] ramAddr_in,
    input  logic [7:0]  ramData_in,
    output logic [7:0]  ramData_out,
    output logic [7:0]  txData_out,
    output logic        txValid_out,
    input  logic        txReady_in,
    output logic        halt_out,
    output logic        overflow_out
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    // Selects which registered source drives ramData_out, so the array read
    // port stays a plain enabled register without reset.
    typedef enum logic {SRC_IO, SRC_MEM} src_e;

    logic [7:0]        mem_q [0:(1 << RAM_AW) - 1];
    logic [7:0]        mem_rdata_q;
    logic [7:0]        io_rdata_q;
    logic [7:0]        io_rdata_d;
    src_e              src_q;

    logic [7:0]        fifo_q [0:FIFO_DEPTH - 1];
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              halt_q;
    logic              ovf_q;

`ifdef CYCLE_CNT_EN
    logic [31:0]       cnt_q;
    logic [31:0]       snap_q;
`endif

    logic              io_sel;
    logic [2:0]        off;
    logic [RAM_AW-1:0] idx;
    logic              wr_ok;
    logic              rd_req;
    logic              mem_wr;
    logic              mem_rd;
    logic              io_rd;
    logic              push;
    logic              push_acc;
    logic              drop;
    logic              pop;
    logic              full;
    logic              halt_set;

    // Decode
    assign io_sel   = (ramAddr_in[31:3] == IO_BASE[31:3]);
    assign off      = ramAddr_in[2:0];
    assign idx      = ramAddr_in[RAM_AW-1:0];
    assign wr_ok    = en_in && ramRW_in && !halt_q;
    assign rd_req   = en_in && !ramRW_in;
    assign mem_wr   = wr_ok && !io_sel;
    assign mem_rd   = rd_req && !io_sel;
    assign io_rd    = rd_req && io_sel;
    assign push     = wr_ok && io_sel && (off == 3'd0);
    assign halt_set = wr_ok && io_sel && (off == 3'd4);

    // FIFO control: a pop frees the slot a full-FIFO push needs
    assign txValid_out = (count_q != '0);
    assign pop         = txValid_out && txReady_in;
    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign push_acc    = push && (!full || pop);
    assign drop        = push && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push_acc && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_acc && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        io_rdata_d = '0;
        case (off)
            3'd0:    io_rdata_d = 8'(count_q);
`ifdef CYCLE_CNT_EN
            3'd4:    io_rdata_d = cnt_q[7:0];
            3'd5:    io_rdata_d = snap_q[15:8];
            3'd6:    io_rdata_d = snap_q[23:16];
            3'd7:    io_rdata_d = snap_q[31:24];
`endif
            default: io_rdata_d = '0;
        endcase
    end

    // Storage array and FIFO buffer carry no reset
    always_ff @(posedge clk_in) begin
        if (mem_wr) begin
            mem_q[idx] <= ramData_in;
        end
        if (mem_rd) begin
            mem_rdata_q <= mem_q[idx];
        end
        if (push_acc) begin
            fifo_q[wptr_q] <= ramData_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            src_q      <= SRC_IO;
            io_rdata_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            halt_q     <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef CYCLE_CNT_EN
            cnt_q      <= '0;
            snap_q     <= '0;
`endif
        end else begin
            if (io_rd) begin
                io_rdata_q <= io_rdata_d;
                src_q      <= SRC_IO;
            end else if (mem_rd) begin
                src_q      <= SRC_MEM;
            end
            if (push_acc) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_d;
            if (halt_set) begin
                halt_q <= 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
`ifdef CYCLE_CNT_EN
            if (!halt_q) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (io_rd && (off == 3'd4)) begin
                snap_q <= cnt_q;
            end
`endif
        end
    end

    assign ramData_out  = (src_q == SRC_MEM) ? mem_rdata_q : io_rdata_q;
    assign txData_out   = txValid_out ? fifo_q[rptr_q] : '0;
    assign halt_out     = halt_q;
    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        en_in;
    logic        ramRW_in;
    logic [31:0] ramAddr_in;
    logic [7:0]  ramData_in;
    logic [7:0]  ramData_out;
    logic [7:0]  txData_out;
    logic        txValid_out;
    logic        txReady_in;
    logic        halt_out;
    logic        overflow_out;

    int tests = 0;
    int fails = 0;

    ram_responder #(
        .RAM_AW    (17),
        .IO_BASE   (32'h0003_0000),
        .FIFO_DEPTH(8)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en_in       (en_in),
        .ramRW_in    (ramRW_in),
        .ramAddr_in  (ramAddr_in),
        .ramData_in  (ramData_in),
        .ramData_out (ramData_out),
        .txData_out  (txData_out),
        .txValid_out (txValid_out),
        .txReady_in  (txReady_in),
        .halt_out    (halt_out),
        .overflow_out(overflow_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        en;
        logic        rw;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic        rdy;
        logic        chk_rd;
        logic [7:0]  exp_rd;
        logic        exp_valid;
        logic [7:0]  exp_tx;
        logic        exp_halt;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic rw, input logic [31:0] addr,
                       input logic [7:0] wdata, input logic rdy, input logic chk_rd,
                       input logic [7:0] exp_rd, input logic exp_valid,
                       input logic [7:0] exp_tx, input logic exp_halt,
                       input logic exp_ovf);
        vec_t v;
        v.en = en; v.rw = rw; v.addr = addr; v.wdata = wdata; v.rdy = rdy;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_valid = exp_valid;
        v.exp_tx = exp_tx; v.exp_halt = exp_halt; v.exp_ovf = exp_ovf;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic rw, input logic [31:0] addr,
                         input logic [7:0] data, input logic rdy);
        en_in = en; ramRW_in = rw; ramAddr_in = addr; ramData_in = data; txReady_in = rdy;
    endtask

    // One clock edge, then settle away from it
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Called at posedge+1; reset pulse lies entirely between edges
    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
        #1 rst_in = 1'b0;
        #5 rst_in = 1'b1;
        step();
    endtask

    logic [7:0] b4, b5, b6, b7;
    logic [31:0] snap_a, snap_b;
    logic [7:0] exp_out [8];

    initial begin
        rst_in = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
        #3 rst_in = 1'b0;
        #1;
        check("reset_rdata", 32'(ramData_out), 32'h0);
        check("reset_valid", 32'(txValid_out), 32'h0);
        check("reset_txdata", 32'(txData_out), 32'h0);
        check("reset_halt", 32'(halt_out), 32'h0);
        check("reset_ovf", 32'(overflow_out), 32'h0);
        #13 rst_in = 1'b1;
        step();

        // ---------------- table-driven sequence ----------------
        add(1, 1, 32'h0000_0100, 8'hA5, 0, 1, 8'h00, 0, 8'h00, 0, 0);
        add(1, 0, 32'h0000_0100, 8'h00, 0, 1, 8'hA5, 0, 8'h00, 0, 0);
        add(1, 0, 32'h0002_0100, 8'h00, 0, 1, 8'hA5, 0, 8'h00, 0, 0);
        add(1, 1, 32'h0000_0010, 8'h13, 0, 1, 8'hA5, 0, 8'h00, 0, 0);
        add(1, 1, 32'h0000_0011, 8'h00, 0, 1, 8'hA5, 0, 8'h00, 0, 0);
        add(1, 1, 32'h0000_0012, 8'h05, 0, 1, 8'hA5, 0, 8'h00, 0, 0);
        add(1, 1, 32'h0000_0013, 8'h93, 0, 1, 8'hA5, 0, 8'h00, 0, 0);
        add(1, 0, 32'h0000_0010, 8'h00, 0, 1, 8'h13, 0, 8'h00, 0, 0);
        add(1, 0, 32'h0000_0011, 8'h00, 0, 1, 8'h00, 0, 8'h00, 0, 0);
        add(1, 0, 32'h0000_0012, 8'h00, 0, 1, 8'h05, 0, 8'h00, 0, 0);
        add(1, 0, 32'h0000_0013, 8'h00, 0, 1, 8'h93, 0, 8'h00, 0, 0);
        for (int i = 0; i < 9; i++) begin
            add(1, 1, 32'h0003_0000, 8'(8'h41 + i), 0, 1, 8'h93, 1, 8'h41, 0, (i == 8));
        end
        add(1, 0, 32'h0003_0000, 8'h00, 0, 1, 8'h08, 1, 8'h41, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            add(0, 0, 32'h0, 8'h00, 1, 1, 8'h08, (k < 8), 8'(8'h41 + k), 0, 1);
        end
        add(1, 0, 32'h0003_0000, 8'h00, 1, 1, 8'h00, 0, 8'h00, 0, 1);
        add(1, 0, 32'h0003_0001, 8'h00, 0, 1, 8'h00, 0, 8'h00, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
            step();
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_rdata", i), 32'(ramData_out), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_valid", i), 32'(txValid_out), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_txdata", i), 32'(txData_out), 32'(vecs[i].exp_tx));
            check($sformatf("vec%0d_halt", i), 32'(halt_out), 32'(vecs[i].exp_halt));
            check($sformatf("vec%0d_ovf", i), 32'(overflow_out), 32'(vecs[i].exp_ovf));
        end

        // ---------------- full FIFO push + pop ----------------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 32'h0003_0000, 8'(8'h61 + i), 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0);
        step();
        check("full_occ", 32'(ramData_out), 32'd8);
        check("full_ovf", 32'(overflow_out), 32'h0);
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h5A, 1'b1);
        step();
        check("pushpop_ovf", 32'(overflow_out), 32'h0);
        check("pushpop_head", 32'(txData_out), 32'h62);
        drive(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0);
        step();
        check("pushpop_occ", 32'(ramData_out), 32'd8);
        for (int i = 0; i < 7; i++) exp_out[i] = 8'(8'h62 + i);
        exp_out[7] = 8'h5A;
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_valid", i), 32'(txValid_out), 32'h1);
            check($sformatf("drain%0d_data", i), 32'(txData_out), 32'(exp_out[i]));
            step();
        end
        check("drain_empty", 32'(txValid_out), 32'h0);
        check("drain_ovf", 32'(overflow_out), 32'h0);

        // ---------------- halt and counter ----------------
        do_reset();
        repeat (99) step();
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0); step(); b4 = ramData_out;
        drive(1'b1, 1'b0, 32'h0003_0005, 8'h00, 1'b0); step(); b5 = ramData_out;
        drive(1'b1, 1'b0, 32'h0003_0006, 8'h00, 1'b0); step(); b6 = ramData_out;
        drive(1'b1, 1'b0, 32'h0003_0007, 8'h00, 1'b0); step(); b7 = ramData_out;
`ifdef CYCLE_CNT_EN
        tests++;
        if (b4 < 8'd95 || b4 > 8'd105) begin
            fails++;
            $display("FAIL snap_b0: got %0d, expected 95..105", b4);
        end
        check("snap_upper", {8'h0, b7, b6, b5}, 32'h0);
`else
        check("nocnt_bytes", {b7, b6, b5, b4}, 32'h0);
`endif
        drive(1'b1, 1'b1, 32'h0003_0004, 8'h01, 1'b0);
        step();
        check("halt_set", 32'(halt_out), 32'h1);
        drive(1'b1, 1'b1, 32'h0000_0100, 8'h11, 1'b0); step();
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h77, 1'b0); step();
        check("halt_fifo_ignored", 32'(txValid_out), 32'h0);
        drive(1'b1, 1'b0, 32'h0000_0100, 8'h00, 1'b0); step();
        check("halt_mem_ignored", 32'(ramData_out), 32'hA5);
        for (int s = 0; s < 2; s++) begin
            drive(1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b0); step(); b4 = ramData_out;
            drive(1'b1, 1'b0, 32'h0003_0005, 8'h00, 1'b0); step(); b5 = ramData_out;
            drive(1'b1, 1'b0, 32'h0003_0006, 8'h00, 1'b0); step(); b6 = ramData_out;
            drive(1'b1, 1'b0, 32'h0003_0007, 8'h00, 1'b0); step(); b7 = ramData_out;
            if (s == 0) begin
                snap_a = {b7, b6, b5, b4};
                drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
                repeat (10) step();
            end else begin
                snap_b = {b7, b6, b5, b4};
            end
        end
`ifdef CYCLE_CNT_EN
        check("halt_snap_equal", snap_b, snap_a);
`else
        check("nocnt_snap_a", snap_a, 32'h0);
        check("nocnt_snap_b", snap_b, 32'h0);
`endif

        // ---------------- async reset mid-operation ----------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h0003_0000, 8'(8'h31 + i), 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 32'h0003_0004, 8'h00, 1'b0); step();
        drive(1'b1, 1'b0, 32'h0000_0100, 8'h00, 1'b0); step();
        check("pre_rst_halt", 32'(halt_out), 32'h1);
        check("pre_rst_valid", 32'(txValid_out), 32'h1);
        check("pre_rst_rdata", 32'(ramData_out), 32'hA5);
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
        #2 rst_in = 1'b0;
        #1;
        check("async_rdata", 32'(ramData_out), 32'h0);
        check("async_valid", 32'(txValid_out), 32'h0);
        check("async_txdata", 32'(txData_out), 32'h0);
        check("async_halt", 32'(halt_out), 32'h0);
        check("async_ovf", 32'(overflow_out), 32'h0);
        #3 rst_in = 1'b1;
        step();
        drive(1'b1, 1'b0, 32'h0000_0100, 8'h00, 1'b0); step();
        check("post_rst_mem", 32'(ramData_out), 32'hA5);
        drive(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0); step();
        check("post_rst_occ", 32'(ramData_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
